// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Drives an 8-digit multiplexed common-anode seven-segment display from the
// 32-bit value written to the GPIO output port. The value is shown either as
// hex (copied straight into the display register) or as unsigned decimal
// (converted by a serial double-dabble engine, one shift per clock).
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-low
//   dIn       value to display
//   mode      0 = hex, 1 = unsigned decimal
//   blank_lz  1 = blank leading zero digits (digit 0 is never blanked)
//   an        digit enables, active-low, an[0] = rightmost digit
//   seg       segments, active-low, ordered {g,f,e,d,c,b,a}
//   dp        decimal point, active-low (lit on digit 0 in decimal mode)
//   busy      high while a decimal conversion is in progress
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int PRE_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dIn,
    input  logic        mode,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    // One double-dabble iteration on {bcd[39:0], bin[31:0]}: every BCD nibble
    // of 5 or more gets +3 so that the following left shift carries correctly.
    function automatic logic [71:0] dd_step(input logic [71:0] v);
        logic [71:0] t;
        t = v;
        for (int i = 0; i < 10; i++) begin
            if (t[32+4*i +: 4] >= 4'd5) begin
                t[32+4*i +: 4] = t[32+4*i +: 4] + 4'd3;
            end else begin
                t[32+4*i +: 4] = t[32+4*i +: 4];
            end
        end
        return {t[70:0], 1'b0};
    endfunction

    // Nibble to active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [31:0]      shadow_val_q, shadow_val_d;
    logic             shadow_mode_q, shadow_mode_d;
    logic [31:0]      disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic [71:0]      sr_q, sr_d;
    logic [4:0]       iter_q, iter_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             busy_q, busy_d;

    logic             change_s;
    logic [3:0]       nib_s;
    logic             upper_zero_s;

    // Inputs are only compared against the shadows while idle, so edits made
    // during a conversion are picked up once the engine returns to IDLE.
    assign change_s     = (dIn != shadow_val_q) || (mode != shadow_mode_q);
    assign nib_s        = disp_q[{idx_q, 2'b00} +: 4];
    // Digit idx and every digit to its left are zero.
    assign upper_zero_s = ((disp_q >> {idx_q, 2'b00}) == 32'h0);

    // Capture FSM: hex copy, or serial binary-to-BCD conversion and commit.
    always_comb begin
        state_d       = state_q;
        shadow_val_d  = shadow_val_q;
        shadow_mode_d = shadow_mode_q;
        disp_d        = disp_q;
        ovf_d         = ovf_q;
        sr_d          = sr_q;
        iter_d        = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (change_s) begin
                    shadow_val_d  = dIn;
                    shadow_mode_d = mode;
                    if (mode) begin
                        sr_d    = {40'h0, dIn};
                        iter_d  = 5'd0;
                        state_d = ST_CONV;
                    end else begin
                        disp_d = dIn;
                        ovf_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                sr_d   = dd_step(sr_q);
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd31) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_CONV;
                end
            end
            ST_COMMIT: begin
                // Values of 100,000,000 and above need more than 8 digits.
                if (sr_q[71:64] != 8'h00) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d  = 1'b0;
                    disp_d = sr_q[63:32];
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Refresh prescaler and digit scanner.
    always_comb begin
        if (pre_q == PRE_LAST) begin
            pre_d = {PRE_W{1'b0}};
            idx_d = idx_q + 3'd1;
        end else begin
            pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
            idx_d = idx_q;
        end
    end

    // Output stage next values: digit enable, segment pattern, dp and busy.
    always_comb begin
        an_d = ~(8'h01 << idx_q);
        if (ovf_q) begin
            seg_d = 7'h3F;
        end else if (blank_lz && (idx_q != 3'd0) && upper_zero_s) begin
            seg_d = 7'h7F;
        end else begin
            seg_d = seg_decode(nib_s);
        end
        dp_d   = ~((idx_q == 3'd0) && shadow_mode_q);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            shadow_val_q  <= 32'h0;
            shadow_mode_q <= 1'b0;
            disp_q        <= 32'h0;
            ovf_q         <= 1'b0;
            sr_q          <= 72'h0;
            iter_q        <= 5'd0;
            pre_q         <= {PRE_W{1'b0}};
            idx_q         <= 3'd0;
            an_q          <= 8'hFF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_val_q  <= shadow_val_d;
            shadow_mode_q <= shadow_mode_d;
            disp_q        <= disp_d;
            ovf_q         <= ovf_d;
            sr_q          <= sr_d;
            iter_q        <= iter_d;
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            busy_q        <= busy_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;

endmodule
